// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one synchronous SRAM port.
// Round-robin on conflict, single-cycle response routed back via a registered owner tag.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,

  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  typedef enum logic {PortIf = 1'b0, PortD = 1'b1} port_e;

  port_e                last_grant_q;
  logic                 owner_valid_q;
  port_e                owner_port_q;
  logic                 owner_store_q;
  logic [CNT_WIDTH-1:0] conflict_cnt_q;

  // Byte offsets are dropped: the memory is word addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (if_req && d_req) begin
        if (last_grant_q == PortD) if_gnt = 1'b1;
        else                       d_gnt  = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_WIDTH-1:2];
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr[ADDR_WIDTH-1:2];
      mem_we    = d_we ? d_be : 4'b0000;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q   <= PortD;
      owner_valid_q  <= 1'b0;
      owner_port_q   <= PortIf;
      owner_store_q  <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      owner_valid_q <= if_gnt | d_gnt;
      if (if_gnt) begin
        last_grant_q  <= PortIf;
        owner_port_q  <= PortIf;
        owner_store_q <= 1'b0;
      end else if (d_gnt) begin
        last_grant_q  <= PortD;
        owner_port_q  <= PortD;
        owner_store_q <= d_we;
      end
      if (if_req && d_req && (conflict_cnt_q != {CNT_WIDTH{1'b1}})) begin
        conflict_cnt_q <= conflict_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Gating with reset drops a response whose grant preceded the reset cycle.
  always_comb begin
    if_rvalid = !reset && owner_valid_q && (owner_port_q == PortIf);
    d_rvalid  = !reset && owner_valid_q && (owner_port_q == PortD);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !owner_store_q) ? mem_rdata : '0;
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small write-first memory model; a second instance
// with a 4-bit conflict counter shares the stimulus to exercise saturation.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [15:0] conflict_cnt;

  logic        q_if_gnt, q_if_rvalid, q_d_gnt, q_d_rvalid, q_mem_en;
  logic [31:0] q_if_rdata, q_d_rdata, q_mem_wdata;
  logic [3:0]  q_mem_we;
  logic [29:0] q_mem_addr;
  logic [3:0]  q_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  mem_arbiter #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(q_if_gnt), .if_rvalid(q_if_rvalid),
    .if_rdata(q_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(q_d_gnt), .d_rvalid(q_d_rvalid), .d_rdata(q_d_rdata),
    .mem_en(q_mem_en), .mem_we(q_mem_we), .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(q_cnt)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    return w;
  endfunction

  // Write-first memory, one-cycle registered read; word 8 starts zeroed.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 8) ? 32'h0 : 32'h1000_0000 + 32'(i);
    end else if (mem_en) begin
      mem[mem_addr[5:0]] <= merge(mem[mem_addr[5:0]], mem_wdata, mem_we);
      mem_rdata          <= merge(mem[mem_addr[5:0]], mem_wdata, mem_we);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) chk("one_grant", 32'(if_gnt & d_gnt), 32'h0);

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h10; d_addr = 32'h24; d_wdata = 32'h0; d_be = 4'hF;
    cyc(); cyc();
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_cnt", 32'(conflict_cnt), 0);

    // Continuous conflict from reset: IF, D, IF, D
    reset = 1'b0; #1;
    chk("rr1_if_gnt", 32'(if_gnt), 1);
    chk("rr1_d_gnt", 32'(d_gnt), 0);
    chk("rr1_addr", 32'(mem_addr), 32'h4);
    cyc();
    chk("rr1_cnt", 32'(conflict_cnt), 1);
    chk("rr1_if_rvalid", 32'(if_rvalid), 1);
    chk("rr1_if_rdata", if_rdata, 32'h1000_0004);
    chk("rr1_d_rvalid", 32'(d_rvalid), 0);
    chk("rr2_d_gnt", 32'(d_gnt), 1);
    chk("rr2_addr", 32'(mem_addr), 32'h9);
    cyc();
    chk("rr2_d_rvalid", 32'(d_rvalid), 1);
    chk("rr2_d_rdata", d_rdata, 32'h1000_0009);
    chk("rr2_if_rvalid", 32'(if_rvalid), 0);
    chk("rr3_if_gnt", 32'(if_gnt), 1);
    cyc();
    chk("rr4_d_gnt", 32'(d_gnt), 1);
    cyc();
    chk("rr_cnt4", 32'(conflict_cnt), 4);
    chk("rr_cnt4_w4", 32'(q_cnt), 4);

    // Fetch only, three back-to-back grants
    d_req = 1'b0; #1;
    chk("rr4_d_rvalid", 32'(d_rvalid), 1);
    chk("rr4_d_rdata", d_rdata, 32'h1000_0009);
    for (int i = 0; i < 3; i++) begin
      chk("fo_if_gnt", 32'(if_gnt), 1);
      chk("fo_mem_en", 32'(mem_en), 1);
      chk("fo_addr", 32'(mem_addr), 32'h4);
      chk("fo_we", 32'(mem_we), 0);
      cyc();
      chk("fo_rvalid", 32'(if_rvalid), 1);
      chk("fo_rdata", if_rdata, 32'h1000_0004);
    end

    // Idle
    if_req = 1'b0; #1;
    chk("idle_en", 32'(mem_en), 0);
    chk("idle_addr", 32'(mem_addr), 0);
    chk("idle_we", 32'(mem_we), 0);
    chk("idle_wdata", mem_wdata, 0);
    chk("idle_if_gnt", 32'(if_gnt), 0);
    cyc();
    chk("idle_if_rvalid", 32'(if_rvalid), 0);
    chk("idle_d_rvalid", 32'(d_rvalid), 0);
    chk("idle_cnt", 32'(conflict_cnt), 4);

    // Partial store then load of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; #1;
    chk("st_gnt", 32'(d_gnt), 1);
    chk("st_we", 32'(mem_we), 32'h3);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_addr", 32'(mem_addr), 32'h8);
    cyc();
    chk("st_rvalid", 32'(d_rvalid), 1);
    chk("st_rdata", d_rdata, 0);
    d_we = 1'b0; #1;
    chk("ld_gnt", 32'(d_gnt), 1);
    chk("ld_we", 32'(mem_we), 0);
    cyc();
    chk("ld_rvalid", 32'(d_rvalid), 1);
    chk("ld_rdata", d_rdata, 32'h0000_BEEF);
    chk("ld_if_rvalid", 32'(if_rvalid), 0);

    // Fetch redirect with a load in between
    if_req = 1'b1; if_addr = 32'h10; d_addr = 32'h24; #1;
    chk("jr1_if_gnt", 32'(if_gnt), 1);
    chk("jr1_d_gnt", 32'(d_gnt), 0);
    cyc();
    chk("jr1_if_rvalid", 32'(if_rvalid), 1);
    chk("jr1_if_rdata", if_rdata, 32'h1000_0004);
    chk("jr1_d_rvalid", 32'(d_rvalid), 0);
    if_addr = 32'h40; #1;
    chk("jr2_d_gnt", 32'(d_gnt), 1);
    chk("jr2_if_gnt", 32'(if_gnt), 0);
    chk("jr2_addr", 32'(mem_addr), 32'h9);
    cyc();
    chk("jr2_d_rvalid", 32'(d_rvalid), 1);
    chk("jr2_d_rdata", d_rdata, 32'h1000_0009);
    chk("jr2_if_rvalid", 32'(if_rvalid), 0);
    chk("jr2_if_rdata", if_rdata, 0);
    d_req = 1'b0; #1;
    chk("jr3_if_gnt", 32'(if_gnt), 1);
    chk("jr3_addr", 32'(mem_addr), 32'h10);
    cyc();
    chk("jr3_if_rvalid", 32'(if_rvalid), 1);
    chk("jr3_if_rdata", if_rdata, 32'h1000_0010);
    chk("jr3_d_rvalid", 32'(d_rvalid), 0);
    chk("jr_cnt", 32'(conflict_cnt), 6);

    // Reset right after a fetch grant
    if_addr = 32'h10; #1;
    chk("rg_if_gnt", 32'(if_gnt), 1);
    cyc();
    reset = 1'b1; d_req = 1'b1; #1;
    chk("rg_if_rvalid", 32'(if_rvalid), 0);
    chk("rg_if_rdata", if_rdata, 0);
    chk("rg_d_rvalid", 32'(d_rvalid), 0);
    chk("rg_if_gnt0", 32'(if_gnt), 0);
    chk("rg_d_gnt0", 32'(d_gnt), 0);
    cyc();
    reset = 1'b0; #1;
    chk("rg_cnt", 32'(conflict_cnt), 0);
    chk("rg_first_if", 32'(if_gnt), 1);
    chk("rg_first_d", 32'(d_gnt), 0);
    cyc();
    chk("rg_cnt1", 32'(conflict_cnt), 1);

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_w4", 32'(q_cnt), 32'hF);
    chk("sat_w16", 32'(conflict_cnt), 21);

    if_req = 1'b0; d_req = 1'b0;
    cyc(); cyc();
    chk("end_cnt_hold", 32'(conflict_cnt), 21);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
